// File: rtl/i2c_pad_arbiter_pkg.sv
// Shared types and sizing helpers for the I2C pad arbiter.
package i2c_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GUARD = 2'd2
    } arb_state_e;

    // Bits needed to hold a saturating counter that stops at max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int ptr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2c_pad_arbiter_if.sv
// Bus-side bundle of the arbiter: per-master request/grant and pad ports plus the shared pad set.
interface i2c_pad_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] gnt_o;
    logic [N_REQ-1:0] m_scl_pad_o;
    logic [N_REQ-1:0] m_scl_padoen_o;
    logic [N_REQ-1:0] m_sda_pad_o;
    logic [N_REQ-1:0] m_sda_padoen_o;
    logic [N_REQ-1:0] m_scl_pad_i;
    logic [N_REQ-1:0] m_sda_pad_i;
    logic             scl_pad_i;
    logic             sda_pad_i;
    logic             scl_pad_o;
    logic             sda_pad_o;
    logic             scl_padoen_o;
    logic             sda_padoen_o;
    logic             busy_o;
    logic             timeout_o;

    // Arbiter side.
    modport slave (
        input  req_i, m_scl_pad_o, m_scl_padoen_o, m_sda_pad_o, m_sda_padoen_o,
               scl_pad_i, sda_pad_i,
        output gnt_o, m_scl_pad_i, m_sda_pad_i, scl_pad_o, sda_pad_o,
               scl_padoen_o, sda_padoen_o, busy_o, timeout_o
    );

    // Masters plus pad ring side.
    modport master (
        output req_i, m_scl_pad_o, m_scl_padoen_o, m_sda_pad_o, m_sda_padoen_o,
               scl_pad_i, sda_pad_i,
        input  gnt_o, m_scl_pad_i, m_sda_pad_i, scl_pad_o, sda_pad_o,
               scl_padoen_o, sda_padoen_o, busy_o, timeout_o
    );

endinterface

// File: rtl/i2c_pad_arbiter_rr_picker.sv
// Combinational round-robin select: first set request after ptr_i, wrapping, as one-hot plus index.
module rr_picker
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // Walk offsets from farthest to nearest so the nearest hit after ptr_i overwrites the rest.
        for (int off = N_REQ; off >= 1; off--) begin
            int j;
            j = (int'(ptr_i) + off) % N_REQ;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = PTR_W'(j);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_pad_arbiter.sv
// Transaction-granular round-robin owner of one shared I2C pad set among N_REQ masters.
// Optional grant timeout with lockout: define I2C_ARB_TIMEOUT_EN.
module i2c_pad_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int GUARD_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    i2c_pad_arbiter_if.slave bus
);

    localparam int PTR_W = ptr_width(N_REQ);
    localparam int GW    = cnt_width(GUARD_CYCLES);
    localparam logic [GW-1:0] GUARD_END = GW'(GUARD_CYCLES);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [GW-1:0]    guard_cnt_q, guard_cnt_d;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;
    logic             owner_req;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic             timeout_q, timeout_d;
    logic [N_REQ-1:0] lock_q, lock_d;

    assign elig = bus.req_i & ~lock_q;
`else
    assign elig = bus.req_i;
`endif

    assign owner_req = |(gnt_q & bus.req_i);

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        guard_cnt_d = guard_cnt_q;
`ifdef I2C_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        timeout_d = 1'b0;
        lock_d    = lock_q & bus.req_i;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                guard_cnt_d = '0;
`ifdef I2C_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                if (pick_valid) begin
                    state_d = ARB_GRANT;
                    gnt_d   = pick_gnt;
                    ptr_d   = pick_idx;
`ifdef I2C_ARB_TIMEOUT_EN
                    to_cnt_d = TW'(1);
`endif
                end
            end
            ARB_GRANT: begin
                // The cycle of leaving GRANT already counts as the first released guard cycle.
                if (!owner_req) begin
                    state_d     = ARB_GUARD;
                    gnt_d       = '0;
                    guard_cnt_d = GW'(1);
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_END) begin
                    state_d     = ARB_GUARD;
                    gnt_d       = '0;
                    guard_cnt_d = GW'(1);
                    timeout_d   = 1'b1;
                    lock_d      = lock_d | gnt_q;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
`endif
            end
            ARB_GUARD: begin
                // A slave still stretching SCL or holding SDA keeps us here indefinitely.
                if (guard_cnt_q == GUARD_END && bus.scl_pad_i && bus.sda_pad_i) begin
                    state_d     = ARB_IDLE;
                    guard_cnt_d = '0;
                end else if (guard_cnt_q != GUARD_END) begin
                    guard_cnt_d = guard_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            ptr_q       <= '0;
            guard_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            guard_cnt_q <= guard_cnt_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            lock_q    <= '0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            lock_q    <= lock_d;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

    // Pad mux straight from the registered grant; an empty grant releases both lines.
    assign bus.scl_pad_o    = |(gnt_q & bus.m_scl_pad_o);
    assign bus.sda_pad_o    = |(gnt_q & bus.m_sda_pad_o);
    assign bus.scl_padoen_o = ~|(gnt_q & ~bus.m_scl_padoen_o);
    assign bus.sda_padoen_o = ~|(gnt_q & ~bus.m_sda_padoen_o);
    assign bus.m_scl_pad_i  = ~gnt_q | {N_REQ{bus.scl_pad_i}};
    assign bus.m_sda_pad_i  = ~gnt_q | {N_REQ{bus.sda_pad_i}};

    assign bus.gnt_o  = gnt_q;
    assign bus.busy_o = (state_q != ARB_IDLE);

endmodule
